// File: rtl/apb_master_pkg.sv
// Shared types and defaults for the APB master bridge.
// The state encoding is exposed here so checkers and other blocks can decode it.
package apb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_mst_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage : apb_master_pkg

// File: rtl/apb_master_bridge.sv
// Single-outstanding request/response to APB master bridge with an ACCESS-phase timeout.
// One command is in flight at a time; the response is held until consumed.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 14,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_write_i,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic [APB_DATA_WIDTH-1:0] resp_rdata_o,
  output logic                      resp_err_o,
  output logic                      resp_timeout_o,
  output logic [APB_ADDR_WIDTH-1:0] apb_paddr_o,
  output logic [APB_DATA_WIDTH-1:0] apb_pwdata_o,
  output logic                      apb_pwrite_o,
  output logic                      apb_psel_o,
  output logic                      apb_penable_o,
  input  logic [APB_DATA_WIDTH-1:0] apb_prdata_i,
  input  logic                      apb_pready_i,
  input  logic                      apb_pslverr_i
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  apb_mst_state_t             state_r;
  logic [CNT_W-1:0]           cnt_r;
  logic [APB_ADDR_WIDTH-1:0]  paddr_r;
  logic [APB_DATA_WIDTH-1:0]  pwdata_r;
  logic                       pwrite_r;
  logic                       psel_r;
  logic                       penable_r;
  logic                       resp_valid_r;
  logic [APB_DATA_WIDTH-1:0]  resp_rdata_r;
  logic                       resp_err_r;
  logic                       resp_timeout_r;
  logic [APB_DATA_WIDTH-1:0]  rdata_s;

  // Read data returned to the requester: only a successful read carries slave data.
  always_comb begin
    rdata_s = {APB_DATA_WIDTH{1'b0}};
    if (!pwrite_r && !apb_pslverr_i) begin
      rdata_s = apb_prdata_i;
    end else begin
      rdata_s = {APB_DATA_WIDTH{1'b0}};
    end
  end

  // Transaction FSM with all APB and response outputs registered.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r        <= ST_IDLE;
      cnt_r          <= {CNT_W{1'b0}};
      paddr_r        <= {APB_ADDR_WIDTH{1'b0}};
      pwdata_r       <= {APB_DATA_WIDTH{1'b0}};
      pwrite_r       <= 1'b0;
      psel_r         <= 1'b0;
      penable_r      <= 1'b0;
      resp_valid_r   <= 1'b0;
      resp_rdata_r   <= {APB_DATA_WIDTH{1'b0}};
      resp_err_r     <= 1'b0;
      resp_timeout_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid_i) begin
            paddr_r   <= req_addr_i;
            pwdata_r  <= req_wdata_i;
            pwrite_r  <= req_write_i;
            psel_r    <= 1'b1;
            penable_r <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            state_r   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_r <= 1'b1;
          state_r   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // A slave completing on the last allowed cycle still wins over the abort.
          if (apb_pready_i) begin
            psel_r         <= 1'b0;
            penable_r      <= 1'b0;
            resp_valid_r   <= 1'b1;
            resp_rdata_r   <= rdata_s;
            resp_err_r     <= apb_pslverr_i;
            resp_timeout_r <= 1'b0;
            state_r        <= ST_RESP;
          end else if (cnt_r == CNT_LAST) begin
            psel_r         <= 1'b0;
            penable_r      <= 1'b0;
            resp_valid_r   <= 1'b1;
            resp_rdata_r   <= {APB_DATA_WIDTH{1'b0}};
            resp_err_r     <= 1'b1;
            resp_timeout_r <= 1'b1;
            state_r        <= ST_RESP;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_RESP: begin
          if (resp_ready_i) begin
            resp_valid_r <= 1'b0;
            state_r      <= ST_IDLE;
          end
        end
        default: begin
          psel_r       <= 1'b0;
          penable_r    <= 1'b0;
          resp_valid_r <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  // Gated by reset so the handshake stays low while the bridge is held in reset.
  assign req_ready_o    = (state_r == ST_IDLE) && rstn_i;
  assign resp_valid_o   = resp_valid_r;
  assign resp_rdata_o   = resp_rdata_r;
  assign resp_err_o     = resp_err_r;
  assign resp_timeout_o = resp_timeout_r;
  assign apb_paddr_o    = paddr_r;
  assign apb_pwdata_o   = pwdata_r;
  assign apb_pwrite_o   = pwrite_r;
  assign apb_psel_o     = psel_r;
  assign apb_penable_o  = penable_r;

endmodule : apb_master_bridge

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: a driver/slave task pushes expected
// responses, an independent monitor pops and compares them.
module tb_apb_master_bridge;

  localparam int AW  = 14;
  localparam int DW  = 32;
  localparam int TMO = 16;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    int          lat;
    int          acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_ready, resp_err, resp_timeout;
  logic [DW-1:0] resp_rdata;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic          pwrite, psel, penable, pready, pslverr;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  exp_t q[$];

  apb_master_bridge #(
    .APB_ADDR_WIDTH (AW),
    .APB_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_write_i    (req_write),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_rdata_o   (resp_rdata),
    .resp_err_o     (resp_err),
    .resp_timeout_o (resp_timeout),
    .apb_paddr_o    (paddr),
    .apb_pwdata_o   (pwdata),
    .apb_pwrite_o   (pwrite),
    .apb_psel_o     (psel),
    .apb_penable_o  (penable),
    .apb_prdata_i   (prdata),
    .apb_pready_i   (pready),
    .apb_pslverr_i  (pslverr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One full transaction: request, APB slave behaviour, response backpressure.
  // p = ACCESS cycle on which the slave raises pready (p > TMO means never).
  task automatic do_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input int p, input logic se, input logic [DW-1:0] rd,
                        input int hold, input logic hv);
    exp_t e;
    int   n_acc, n_sel, exp_acc;
    bit   got, done;
    if (p <= TMO) begin
      e.err = se; e.tmo = 1'b0; e.rdata = (!wr && !se) ? rd : 32'h0; exp_acc = p;
    end else begin
      e.err = 1'b1; e.tmo = 1'b1; e.rdata = 32'h0; exp_acc = TMO;
    end
    e.lat = 2 + exp_acc;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    resp_ready = (hold == 0);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready) got = 1;
    end
    check("accept_bound", 32'(got), 32'd1);
    if (!got) begin
      req_valid = 1'b0;
      return;
    end
    e.acc = cyc;
    q.push_back(e);
    @(posedge clk); #1;
    if (hv) begin
      req_addr = AW'($urandom); req_wdata = $urandom; req_write = ~wr;
    end else begin
      req_valid = 1'b0;
    end
    n_acc = 0; n_sel = 0; done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (psel) begin
        n_sel++;
        check("paddr_stable", 32'(paddr), 32'(a));
        check("pwdata_stable", pwdata, wd);
        check("pwrite_stable", 32'(pwrite), 32'(wr));
        if (penable) begin
          n_acc++;
          if (n_acc == p) begin
            pready = 1'b1; pslverr = se; prdata = rd;
          end
        end else begin
          pready = 1'($urandom_range(0, 1)); pslverr = 1'($urandom_range(0, 1));
        end
      end else if (n_sel > 0) begin
        done = 1;
      end
      if (pready) begin
        @(posedge clk); #1;
        pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
      end
    end
    check("apb_done_bound", 32'(done), 32'd1);
    check("access_cycles", 32'(n_acc), 32'(exp_acc));
    check("psel_cycles", 32'(n_sel), 32'(exp_acc + 1));
    check("penable_idle", 32'(penable), 32'd0);
    for (int h = 0; h < hold; h++) begin
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_no_psel", 32'(psel), 32'd0);
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      @(negedge clk);
    end
    #1 resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Reset pulse in the middle of ACCESS: bus drops at once and no response follows.
  task automatic reset_mid_access();
    bit got, saw;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 14'h0123; resp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready) got = 1;
    end
    check("rst_accept", 32'(got), 32'd1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_pre_psel", 32'(psel), 32'd1);
    check("rst_pre_penable", 32'(penable), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("rst_async_psel", 32'(psel), 32'd0);
    check("rst_async_penable", 32'(penable), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_req_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk); #2 rstn = 1'b1;
    @(negedge clk);
    check("rst_req_ready_after", 32'(req_ready), 32'd1);
    saw = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (resp_valid || psel) saw = 1;
    end
    check("rst_no_resp", 32'(saw), 32'd0);
  endtask

  // Monitor: pops an expectation on each new response and re-checks it at consumption.
  initial begin : monitor
    exp_t cur;
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_v = 1'b0;
      end else begin
        if (resp_valid && !prev_v) begin
          if (q.size() == 0) begin
            check("unexpected_resp", 32'd1, 32'd0);
          end else begin
            cur = q.pop_front();
            check("resp_latency", 32'(cyc - cur.acc), 32'(cur.lat));
            check("resp_rdata", resp_rdata, cur.rdata);
            check("resp_err", 32'(resp_err), 32'(cur.err));
            check("resp_timeout", 32'(resp_timeout), 32'(cur.tmo));
          end
        end else if (resp_valid && prev_v && resp_ready) begin
          check("resp_hold_rdata", resp_rdata, cur.rdata);
          check("resp_hold_err", 32'(resp_err), 32'(cur.err));
          check("resp_hold_tmo", 32'(resp_timeout), 32'(cur.tmo));
        end
        prev_v = resp_valid;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b1; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    #2;
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_psel", 32'(psel), 32'd0);
    check("reset_penable", 32'(penable), 32'd0);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_paddr", 32'(paddr), 32'd0);
    check("reset_pwdata", pwdata, 32'd0);
    #20 rstn = 1'b1;
    @(negedge clk);
    check("release_req_ready", 32'(req_ready), 32'd1);

    do_txn(1'b1, 14'h0004, 32'h0000_1241, 3, 1'b0, 32'h1111_2222, 0, 1'b0);
    do_txn(1'b0, 14'h2580, 32'h0, 1, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);
    do_txn(1'b0, 14'h0010, 32'h0, 2, 1'b1, 32'h5555_AAAA, 0, 1'b0);
    do_txn(1'b0, 14'h0020, 32'h0, 1000, 1'b0, 32'h0BAD_F00D, 0, 1'b0);
    do_txn(1'b0, 14'h0024, 32'h0, TMO, 1'b0, 32'h0600_D000, 0, 1'b0);
    do_txn(1'b1, 14'h0100, 32'hCAFE_0001, 2, 1'b0, 32'h0, 5, 1'b1);
    reset_mid_access();

    for (int i = 0; i < 40; i++) begin
      do_txn(1'($urandom_range(0, 1)), AW'($urandom), $urandom,
             $urandom_range(1, 20), 1'($urandom_range(0, 3) == 0), $urandom,
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_apb_master_bridge
